// File: rtl/simon_pkg.sv
// Shared types for the SIMON stream controller: default geometry,
// block/key typedefs and the key/data FSM state encodings.
package simon_pkg;
  localparam int N_DEF     = 48;
  localparam int M_DEF     = 3;
  localparam int DEPTH_DEF = 4;

  typedef logic [2*N_DEF-1:0]     blk_t;
  typedef logic [M_DEF*N_DEF-1:0] key_t;

  typedef enum logic [1:0] {K_IDLE, K_REQ, K_WAIT, K_RDY} kst_e;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_BUSY, D_ACK} dst_e;
endpackage

// File: rtl/simon_stream_ctrl_if.sv
// Host-side block stream: ready/valid push of plaintext blocks and
// ready/valid pop of results.
interface simon_stream_ctrl_if import simon_pkg::*; #(
  parameter int N = N_DEF
) ();
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] in_block;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_block;

  modport master (output in_valid, in_block, out_ready,
                  input  in_ready, out_valid, out_block);
  modport slave  (input  in_valid, in_block, out_ready,
                  output in_ready, out_valid, out_block);
endinterface

// File: rtl/simon_blk_fifo.sv
// Block FIFO with wrap-bit pointers; a push while full is dropped even when
// a pop happens in the same cycle.
module simon_blk_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nR,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rp <= rp + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/simon_stream_ctrl.sv
// Feeds host blocks one at a time to a SIMON core and returns results in order.
// Define SIMON_CTRL_STATS_EN to add the blocks_issued/blocks_returned counters.
module simon_stream_ctrl import simon_pkg::*; #(
  parameter int N     = N_DEF,
  parameter int M     = M_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             nR,
  simon_stream_ctrl_if.slave host,
  input  logic             mode_enc,
  input  logic             key_start,
  input  logic [M*N-1:0]   key_in,
  output logic             key_busy,
  output logic             key_ready,
  output logic             newData,
  output logic [2*N-1:0]   plain,
  output logic             enc_dec,
  output logic             readData,
  input  logic             ldData,
  input  logic             doneData,
  input  logic [2*N-1:0]   cipher,
  output logic             newKey,
  output logic [M*N-1:0]   key,
  input  logic             ldKey,
  input  logic             doneKey
`ifdef SIMON_CTRL_STATS_EN
  ,
  output logic [15:0]      blocks_issued,
  output logic [15:0]      blocks_returned
`endif
);
  kst_e kst, kst_nxt;
  dst_e dst, dst_nxt;

  logic             new_key_nxt, key_ready_nxt, new_data_nxt, enc_dec_nxt, read_data_nxt;
  logic [M*N-1:0]   key_nxt;
  logic [2*N-1:0]   plain_nxt, out_block_q, out_block_nxt, fifo_head;
  logic             out_valid_q, out_valid_nxt;
  logic             fifo_full, fifo_empty, fifo_pop, capture;
  logic             in_flight, key_go, issue;

  simon_blk_fifo #(.W(2*N), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nR    (nR),
    .push  (host.in_valid),
    .din   (host.in_block),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign host.in_ready  = ~fifo_full;
  assign host.out_valid = out_valid_q;
  assign host.out_block = out_block_q;

  assign key_busy  = (kst == K_REQ) || (kst == K_WAIT);
  assign in_flight = (dst != D_IDLE);
  assign key_go    = key_start & ~key_busy & ~in_flight;
  // A key reload accepted this cycle blocks issue so no block uses a stale key.
  assign issue     = key_ready & ~key_go & ~fifo_empty & ((dst == D_IDLE) || (dst == D_ACK));

  always_comb begin
    kst_nxt       = kst;
    new_key_nxt   = newKey;
    key_ready_nxt = key_ready;
    key_nxt       = key;
    case (kst)
      K_IDLE, K_RDY: if (key_go) begin
        key_nxt       = key_in;
        new_key_nxt   = 1'b1;
        key_ready_nxt = 1'b0;
        kst_nxt       = K_REQ;
      end
      K_REQ: if (ldKey) begin
        new_key_nxt = 1'b0;
        kst_nxt     = K_WAIT;
      end
      K_WAIT: if (doneKey) begin
        key_ready_nxt = 1'b1;
        kst_nxt       = K_RDY;
      end
      default: kst_nxt = K_IDLE;
    endcase
  end

  always_comb begin
    dst_nxt       = dst;
    new_data_nxt  = newData;
    plain_nxt     = plain;
    enc_dec_nxt   = enc_dec;
    read_data_nxt = readData;
    out_valid_nxt = out_valid_q;
    out_block_nxt = out_block_q;
    fifo_pop      = 1'b0;
    capture       = 1'b0;
    if (out_valid_q && host.out_ready) out_valid_nxt = 1'b0;
    // readData runs independently so a new request can overlap the ack.
    if (readData && !doneData) read_data_nxt = 1'b0;
    case (dst)
      D_IDLE, D_ACK: begin
        if (issue) begin
          plain_nxt    = fifo_head;
          enc_dec_nxt  = mode_enc;
          new_data_nxt = 1'b1;
          dst_nxt      = D_REQ;
        end else if (dst == D_ACK && !doneData) begin
          dst_nxt = D_IDLE;
        end
      end
      D_REQ: if (ldData) begin
        fifo_pop     = 1'b1;
        new_data_nxt = 1'b0;
        dst_nxt      = D_BUSY;
      end
      // Capture only once the previous ack is closed and the result slot frees.
      D_BUSY: if (doneData && !readData && (!out_valid_q || host.out_ready)) begin
        capture       = 1'b1;
        out_block_nxt = cipher;
        out_valid_nxt = 1'b1;
        read_data_nxt = 1'b1;
        dst_nxt       = D_ACK;
      end
      default: dst_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      kst         <= K_IDLE;
      dst         <= D_IDLE;
      newKey      <= 1'b0;
      key_ready   <= 1'b0;
      key         <= '0;
      newData     <= 1'b0;
      plain       <= '0;
      enc_dec     <= 1'b0;
      readData    <= 1'b0;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
    end else begin
      kst         <= kst_nxt;
      dst         <= dst_nxt;
      newKey      <= new_key_nxt;
      key_ready   <= key_ready_nxt;
      key         <= key_nxt;
      newData     <= new_data_nxt;
      plain       <= plain_nxt;
      enc_dec     <= enc_dec_nxt;
      readData    <= read_data_nxt;
      out_valid_q <= out_valid_nxt;
      out_block_q <= out_block_nxt;
    end
  end

`ifdef SIMON_CTRL_STATS_EN
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      blocks_issued   <= '0;
      blocks_returned <= '0;
    end else begin
      if (fifo_pop) blocks_issued   <= blocks_issued + 16'd1;
      if (capture)  blocks_returned <= blocks_returned + 16'd1;
    end
  end
`endif
endmodule

// File: doc/simon_stream_ctrl.md
SIMON_STREAM_CTRL -- requirements
Module: simon_stream_ctrl

Interface
REQ-001 Parameter N, default 48, SIMON word width in bits; block width is 2*N.
REQ-002 Parameter M, default 3, number of key words.
REQ-003 Parameter DEPTH, default 4, input FIFO depth in blocks; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state is updated on the rising edge.
REQ-005 nR  input  1  reset; asynchronous, active-low.
REQ-006 in_valid / in_ready / in_block  input / output / input  1 / 1 / 2*N  host block push, ready/valid.
REQ-007 out_valid / out_ready / out_block  output / input / output  1 / 1 / 2*N  host result pop, ready/valid.
REQ-008 mode_enc  input  1  host mode: 1 = encrypt, 0 = decrypt.
REQ-009 key_start / key_in / key_busy / key_ready  input / input / output / output  1 / M*N / 1 / 1  host key load.
REQ-010 newData, plain, enc_dec, readData  output  1 / 2*N / 1 / 1  core-side data request.
REQ-011 ldData, doneData, cipher  input  1 / 1 / 2*N  core-side data acknowledge and result.
REQ-012 newKey, key  output  1 / M*N  core-side key request.
REQ-013 ldKey, doneKey  input  1 / 1  core-side key acknowledge and key-schedule done.

Function
REQ-014 The block SHALL be the initiator of the newData/ldData/doneData/readData and newKey/ldKey/doneKey handshakes. It feeds host blocks to one cipher core and returns results in order.
REQ-015 Key FSM: states K_IDLE, K_REQ, K_WAIT, K_RDY.
- key_start while key_busy=0 and no block in flight: latch key_in onto key, assert newKey, clear key_ready, enter K_REQ.
- key_start while key_busy=1 or a block is in flight: ignored.
REQ-016 K_REQ: hold newKey=1 until ldKey is sampled high, then drive newKey=0 on the next edge and enter K_WAIT.
REQ-017 K_WAIT: on doneKey sampled high, set key_ready=1 and enter K_RDY. key_busy=1 in K_REQ and K_WAIT only.
REQ-018 in_ready SHALL equal FIFO-not-full. A push when full is not accepted, even if a pop occurs in the same cycle.
REQ-019 Data FSM: states D_IDLE, D_REQ, D_BUSY, D_ACK.
- Issue condition: key_ready=1, FIFO non-empty, and no request outstanding.
- On issue: drive plain=FIFO head, register enc_dec=mode_enc, assert newData, enter D_REQ.
REQ-020 D_REQ: when ldData is sampled high, pop the FIFO, drive newData=0 on the next edge, and enter D_BUSY. plain holds its value until newData falls.
REQ-021 D_BUSY: when doneData is sampled high and out_valid=0:
- capture cipher into out_block;
- set out_valid=1;
- assert readData on the next edge;
- enter D_ACK.
If out_valid=1, hold in D_BUSY with readData=0 (backpressure).
REQ-022 D_ACK: hold readData=1 until doneData is sampled low, then drive readData=0 and return to D_IDLE. A new issue is permitted from the cycle after doneData is sampled high, i.e. overlapped with D_ACK.
REQ-023 out_valid SHALL clear on out_valid & out_ready. A capture and a pop in the same cycle leaves out_valid=1 with the new data.
REQ-024 Maximum one block in flight; results are returned strictly in push order.

Reset
REQ-025 nR low SHALL asynchronously set all of the following to 0: newData, readData, newKey, enc_dec, plain, key, out_valid, out_block, key_busy, key_ready.
REQ-026 nR low SHALL also empty the FIFO and place both FSMs in their IDLE states.
REQ-027 Reset mid-operation discards the in-flight block and the loaded key; a new key load is required after reset.

Configuration
REQ-028 With SIMON_CTRL_STATS_EN defined, the block SHALL add two 16-bit outputs, blocks_issued and blocks_returned.
- blocks_issued increments on each ldData acceptance.
- blocks_returned increments on each result capture.
- Both wrap from 16'hFFFF to 0 and are cleared by reset.
REQ-029 Without SIMON_CTRL_STATS_EN, these ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-030 A shared package simon_pkg SHALL hold the FSM state enums, the default N, M and DEPTH, and the block and key typedefs.
REQ-031 The FIFO SHALL be a sub-module named simon_blk_fifo, parameterised by width and DEPTH.

Verification
REQ-032 The bench SHALL use a core model that:
- asserts ldData 2 cycles after newData rises;
- asserts doneData 6 cycles later with cipher = ~plain;
- drops doneData 1 cycle after readData is seen.
REQ-033 Scenario "reset": hold reset -> all outputs 0, in_ready=1, key_ready=0.
REQ-034 Scenario "key load": key_start with key_in=151413121110_0D0C0B0A0908_050403020100 -> key held, newKey high until ldKey, key_ready=1 after doneKey.
REQ-035 Scenario "stream": push 5 blocks starting 96'h74616874207473756420666F, with out_ready=1 -> 5 results, each ~input, in order; newData never re-asserts before doneData.
REQ-036 Scenario "gating": push blocks before key_ready -> no newData until key_ready=1; after 4 pushes in_ready=0 and the 5th push is held.
REQ-037 Scenario "backpressure": out_ready=0 -> second doneData gets no readData until the first result is popped; no result is lost.
REQ-038 Scenario "reset mid-op": reset during D_BUSY -> state cleared, no out_valid; after a fresh key load, the stream resumes correctly.
